// File: rtl/decoder3to8_seq.sv
// Sequential 3-to-8 decoder: buffered valid/ready input, one-hot word held for HOLD cycles, then GAP zero cycles.
// Optional even-parity check on accepted codes when DEC3TO8_PARITY_EN is defined (adds in_par, err).
module decoder3to8_seq #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_code,
`ifdef DEC3TO8_PARITY_EN
  input  logic       in_par,
  output logic       err,
`endif
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  // HOLD=0 is out of range and behaves like HOLD=1.
  localparam int         HE     = (HOLD < 1) ? 1 : HOLD;
  localparam logic [7:0] HCNT   = 8'(HE - 1);
  localparam logic [7:0] GCNT   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam bit         GAP_ON = (GAP > 0);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] out_nx;
  logic       buf_full, full_nx;
  logic [2:0] buf_code, code_nx;
  logic       acc, par_ok, take, load;

  assign acc = in_valid && in_ready;

`ifdef DEC3TO8_PARITY_EN
  assign par_ok = ~^{in_code, in_par};
`else
  assign par_ok = 1'b1;
`endif

  // A bad-parity handshake still completes, but the code is dropped.
  assign take = acc && par_ok;

  // Next-state, counter, output word and buffer bookkeeping.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    out_nx   = out;
    load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (buf_full) load = 1'b1;
      end
      S_DRIVE: begin
        if (cnt == 8'd0) begin
          if (GAP_ON) begin
            state_nx = S_GAP;
            cnt_nx   = GCNT;
            out_nx   = 8'd0;
          end else if (buf_full) begin
            load = 1'b1;
          end else begin
            state_nx = S_IDLE;
            out_nx   = 8'd0;
          end
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt == 8'd0) begin
          if (buf_full) load = 1'b1;
          else state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        out_nx   = 8'd0;
      end
    endcase
    if (load) begin
      state_nx = S_DRIVE;
      cnt_nx   = HCNT;
      out_nx   = 8'b1 << buf_code;
    end
    // Load needs a full buffer and accept needs an empty one,
    // so they never coincide.
    full_nx = load ? 1'b0 : (take ? 1'b1 : buf_full);
    code_nx = take ? in_code : buf_code;
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      out       <= 8'd0;
      out_valid <= 1'b0;
      buf_full  <= 1'b0;
      buf_code  <= 3'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out       <= out_nx;
      out_valid <= (state_nx == S_DRIVE);
      buf_full  <= full_nx;
      buf_code  <= code_nx;
      in_ready  <= !full_nx;
      busy      <= (state_nx != S_IDLE) || full_nx;
    end
  end

`ifdef DEC3TO8_PARITY_EN
  // One-cycle error pulse after a bad-parity accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= acc && !par_ok;
  end
`endif

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Directed bench for decoder3to8_seq: three instances with different HOLD/GAP.
// Outputs sampled on the falling edge, inputs driven right after sampling.
module tb_decoder3to8_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       va, vb, vc;
  logic [2:0] ca, cb, cc;
  logic       ra, rb, rc;
  logic [7:0] oa, ob, oc;
  logic       ova, ovb, ovc;
  logic       ba, bb, bc;
`ifdef DEC3TO8_PARITY_EN
  logic       pa, pb, pc;
  logic       ea, eb, ec;
`endif

  int total = 0;
  int bad   = 0;

  decoder3to8_seq #(.HOLD(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_code(ca),
`ifdef DEC3TO8_PARITY_EN
    .in_par(pa), .err(ea),
`endif
    .in_ready(ra), .out(oa), .out_valid(ova), .busy(ba)
  );

  decoder3to8_seq #(.HOLD(2), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_code(cb),
`ifdef DEC3TO8_PARITY_EN
    .in_par(pb), .err(eb),
`endif
    .in_ready(rb), .out(ob), .out_valid(ovb), .busy(bb)
  );

  decoder3to8_seq #(.HOLD(3), .GAP(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(vc), .in_code(cc),
`ifdef DEC3TO8_PARITY_EN
    .in_par(pc), .err(ec),
`endif
    .in_ready(rc), .out(oc), .out_valid(ovc), .busy(bc)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    va = 0; vb = 0; vc = 0;
    ca = 0; cb = 0; cc = 0;
`ifdef DEC3TO8_PARITY_EN
    pa = 0; pb = 0; pc = 0;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    logic [2:0] ctab [8];
    logic       pend, prev;
    int         rises;

    ctab = '{3'd1, 3'd5, 3'd2, 3'd7, 3'd4, 3'd3, 3'd0, 3'd6};

    do_reset();
    check("rst out_a", oa, 0);
    check("rst oval_a", ova, 0);
    check("rst rdy_a", ra, 1);
    check("rst busy_a", ba, 0);
    check("rst out_b", ob, 0);
    check("rst rdy_c", rc, 1);
`ifdef DEC3TO8_PARITY_EN
    check("rst err_a", ea, 0);
`endif

    // single code 5, HOLD=4 GAP=1
    for (int k = 0; k <= 8; k++) begin
      e = (k >= 2 && k <= 5) ? 8'h20 : 8'h00;
      check($sformatf("t1 out[%0d]", k), oa, e);
      check($sformatf("t1 oval[%0d]", k), ova, (e != 0));
      check($sformatf("t1 busy[%0d]", k), ba, (k >= 1 && k <= 6));
      va = (k == 0);
      ca = 3'd5;
      @(negedge clk);
    end

    // codes 0..7 back-to-back, HOLD=2 GAP=0
    do_reset();
    vb = 1; cb = 0;
    pend = vb && rb;
    rises = 0;
    prev = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 18; k++) begin
      if (k == 1 || k == 18) e = 8'h00;
      else e = 8'h01 << ((k - 2) / 2);
      check($sformatf("t2 out[%0d]", k), ob, e);
      if (k > 1 && rb && !prev) rises++;
      prev = rb;
      if (pend) begin
        if (cb == 3'd7) vb = 0;
        else cb = cb + 3'd1;
      end
      pend = vb && rb;
      @(negedge clk);
    end
    check("t2 ready rises", rises, 8);

    // codes 1 then 6, HOLD=3 GAP=2
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      if (k >= 2 && k <= 4) e = 8'h02;
      else if (k >= 7 && k <= 9) e = 8'h40;
      else e = 8'h00;
      check($sformatf("t3 out[%0d]", k), oc, e);
      vc = (k <= 2);
      cc = (k == 0) ? 3'd1 : 3'd6;
      @(negedge clk);
    end

    // in_valid held while full: code changes ignored
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      if (k >= 2 && k <= 5) e = 8'h02;
      else if (k >= 7 && k <= 10) e = 8'h04;
      else if (k >= 12 && k <= 15) e = 8'h40;
      else e = 8'h00;
      check($sformatf("t5 out[%0d]", k), oa, e);
      check($sformatf("t5 rdy[%0d]", k), ra,
            (k == 0 || k == 2 || k == 7 || k >= 12));
      va = (k <= 7);
      ca = (k <= 7) ? ctab[k] : 3'd0;
      @(negedge clk);
    end

    // reset mid-DRIVE with a code pending
    do_reset();
    for (int k = 0; k <= 3; k++) begin
      va = (k == 0 || k == 2);
      ca = (k == 0) ? 3'd4 : 3'd5;
      @(negedge clk);
    end
    check("t4 pre out", oa, 8'h10);
    check("t4 pre rdy", ra, 0);
    #2 rst = 1'b1;
    #1;
    check("t4 rst out", oa, 0);
    check("t4 rst oval", ova, 0);
    check("t4 rst rdy", ra, 1);
    check("t4 rst busy", ba, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t4 post out[%0d]", k), oa, 0);
    end

`ifdef DEC3TO8_PARITY_EN
    // bad parity drops the code, good parity decodes it
    do_reset();
    va = 1; ca = 3'd3; pa = 1;
    @(negedge clk);
    va = 0;
    check("tp bad err", ea, 1);
    check("tp bad out", oa, 0);
    check("tp bad rdy", ra, 1);
    check("tp bad busy", ba, 0);
    @(negedge clk);
    check("tp bad err2", ea, 0);
    check("tp bad out2", oa, 0);
    va = 1; ca = 3'd3; pa = 0;
    @(negedge clk);
    va = 0;
    check("tp good err", ea, 0);
    @(negedge clk);
    check("tp good out", oa, 8'h08);
    check("tp good err2", ea, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
